// File: rtl/udp_to_axi.sv
// UDP payload to AXI-Stream receive packer: strips and checks a 4-byte big-endian
// sequence header, packs the payload little-endian into output words and reports errors.
module udp_to_axi #(
    parameter int AXI_DATA_WIDTH       = 32,
    parameter int ETH_UDP_LENGTH_WIDTH = 16
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic [ETH_UDP_LENGTH_WIDTH-1:0] Udp_length,
    input  logic [7:0]                      Udp_data,
    input  logic                            Udp_valid,
    input  logic                            Udp_last,
    output logic                            Udp_ready,
    output logic                            M_axis_valid,
    output logic [AXI_DATA_WIDTH-1:0]       M_axis_data,
    output logic [AXI_DATA_WIDTH/8-1:0]     M_axis_keep,
    output logic                            M_axis_last,
    input  logic                            M_axis_ready,
    output logic [31:0]                     Seq_num,
    output logic                            Seq_error,
    output logic                            Short_packet,
    output logic                            Length_error,
    output logic [31:0]                     Seq_error_count
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LW    = ETH_UDP_LENGTH_WIDTH;

    typedef enum logic {S_HEADER, S_DATA} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                hdr_idx_q, hdr_idx_d;
    logic [23:0]               hdr_q, hdr_d;
    logic                      first_hdr_q, first_hdr_d;
    logic [31:0]               expected_q, expected_d;
    logic [31:0]               seq_num_q, seq_num_d;
    logic                      seq_err_q, seq_err_d;
    logic                      short_q, short_d;
    logic                      len_err_q, len_err_d;
    logic [31:0]               seq_err_cnt_q, seq_err_cnt_d;
    logic [LW-1:0]             byte_cnt_q, byte_cnt_d;
    logic [LW-1:0]             len_q, len_d;
    logic [AXI_DATA_WIDTH-1:0] pack_q, pack_d;
    logic [IDX_W-1:0]          byte_idx_q, byte_idx_d;
    logic                      m_valid_q, m_valid_d;
    logic [AXI_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [BYTES-1:0]          m_keep_q, m_keep_d;
    logic                      m_last_q, m_last_d;

    logic                      accept, first_byte;
    logic [LW-1:0]             cnt_now, len_now;
    logic [31:0]               rx_seq;
    logic [AXI_DATA_WIDTH-1:0] word;
    logic [BYTES-1:0]          keep_new;

    assign Udp_ready       = !m_valid_q || M_axis_ready;
    assign M_axis_valid    = m_valid_q;
    assign M_axis_data     = m_data_q;
    assign M_axis_keep     = m_keep_q;
    assign M_axis_last     = m_last_q;
    assign Seq_num         = seq_num_q;
    assign Seq_error       = seq_err_q;
    assign Short_packet    = short_q;
    assign Length_error    = len_err_q;
    assign Seq_error_count = seq_err_cnt_q;

    always_comb begin
        state_d       = state_q;
        hdr_idx_d     = hdr_idx_q;
        hdr_d         = hdr_q;
        first_hdr_d   = first_hdr_q;
        expected_d    = expected_q;
        seq_num_d     = seq_num_q;
        seq_err_d     = 1'b0;
        short_d       = 1'b0;
        len_err_d     = 1'b0;
        seq_err_cnt_d = seq_err_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        len_d         = len_q;
        pack_d        = pack_q;
        byte_idx_d    = byte_idx_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_keep_d      = m_keep_q;
        m_last_d      = m_last_q;

        accept     = Udp_valid && Udp_ready;
        first_byte = (state_q == S_HEADER) && (hdr_idx_q == 2'd0);
        cnt_now    = first_byte ? LW'(1) : ((&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + LW'(1));
        len_now    = first_byte ? Udp_length : len_q;
        rx_seq     = {hdr_q, Udp_data};

        // pack_q is cleared after every word, so bytes above byte_idx are already zero
        word     = pack_q;
        keep_new = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (k == int'(byte_idx_q)) word[k*8 +: 8] = Udp_data;
            keep_new[k] = (k <= int'(byte_idx_q));
        end

        if (m_valid_q && M_axis_ready) m_valid_d = 1'b0;

        if (accept) begin
            byte_cnt_d = cnt_now;
            len_d      = len_now;
            if (Udp_last && (cnt_now != len_now)) len_err_d = 1'b1;
            case (state_q)
                S_HEADER: begin
                    if (hdr_idx_q != 2'd3) begin
                        hdr_d = {hdr_q[15:0], Udp_data};
                        if (Udp_last) begin
                            short_d   = 1'b1;
                            hdr_idx_d = 2'd0;
                        end else begin
                            hdr_idx_d = hdr_idx_q + 2'd1;
                        end
                    end else begin
                        seq_num_d   = rx_seq;
                        expected_d  = rx_seq + 32'd1;
                        first_hdr_d = 1'b0;
                        if (!first_hdr_q && (rx_seq != expected_q)) begin
                            seq_err_d = 1'b1;
                            if (!(&seq_err_cnt_q)) seq_err_cnt_d = seq_err_cnt_q + 32'd1;
                        end
                        hdr_idx_d = 2'd0;
                        if (!Udp_last) state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if ((byte_idx_q == IDX_W'(BYTES - 1)) || Udp_last) begin
                        m_valid_d  = 1'b1;
                        m_data_d   = word;
                        m_keep_d   = keep_new;
                        m_last_d   = Udp_last;
                        pack_d     = '0;
                        byte_idx_d = '0;
                    end else begin
                        pack_d     = word;
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                    if (Udp_last) state_d = S_HEADER;
                end
                default: state_d = S_HEADER;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= S_HEADER;
            hdr_idx_q     <= 2'd0;
            hdr_q         <= '0;
            first_hdr_q   <= 1'b1;
            expected_q    <= '0;
            seq_num_q     <= '0;
            seq_err_q     <= 1'b0;
            short_q       <= 1'b0;
            len_err_q     <= 1'b0;
            seq_err_cnt_q <= '0;
            byte_cnt_q    <= '0;
            len_q         <= '0;
            pack_q        <= '0;
            byte_idx_q    <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_keep_q      <= '0;
            m_last_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_idx_q     <= hdr_idx_d;
            hdr_q         <= hdr_d;
            first_hdr_q   <= first_hdr_d;
            expected_q    <= expected_d;
            seq_num_q     <= seq_num_d;
            seq_err_q     <= seq_err_d;
            short_q       <= short_d;
            len_err_q     <= len_err_d;
            seq_err_cnt_q <= seq_err_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            len_q         <= len_d;
            pack_q        <= pack_d;
            byte_idx_q    <= byte_idx_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_keep_q      <= m_keep_d;
            m_last_q      <= m_last_d;
        end
    end
endmodule

// File: tb/tb_udp_to_axi.sv
// Bench for udp_to_axi: directed packets plus randomized traffic with backpressure,
// checked against a packet-level model of the expected words and status events.
module tb_udp_to_axi;
    localparam int W  = 32;
    localparam int B  = W / 8;
    localparam int LW = 16;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [LW-1:0] Udp_length;
    logic [7:0]    Udp_data;
    logic          Udp_valid, Udp_last, Udp_ready;
    logic          M_axis_valid, M_axis_last, M_axis_ready;
    logic [W-1:0]  M_axis_data;
    logic [B-1:0]  M_axis_keep;
    logic [31:0]   Seq_num, Seq_error_count;
    logic          Seq_error, Short_packet, Length_error;

    udp_to_axi #(.AXI_DATA_WIDTH(W), .ETH_UDP_LENGTH_WIDTH(LW)) dut (
        .Clk(Clk), .Rst(Rst), .Udp_length(Udp_length), .Udp_data(Udp_data),
        .Udp_valid(Udp_valid), .Udp_last(Udp_last), .Udp_ready(Udp_ready),
        .M_axis_valid(M_axis_valid), .M_axis_data(M_axis_data), .M_axis_keep(M_axis_keep),
        .M_axis_last(M_axis_last), .M_axis_ready(M_axis_ready), .Seq_num(Seq_num),
        .Seq_error(Seq_error), .Short_packet(Short_packet), .Length_error(Length_error),
        .Seq_error_count(Seq_error_count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic [B-1:0] k;
        logic         l;
    } word_t;

    int    n_chk = 0, n_fail = 0;
    int    rdy_pct = 100;
    word_t exp_q[$];
    word_t got_q[$];
    int    seen_seq_err = 0, seen_short = 0, seen_len_err = 0;
    int    m_seq_err = 0, m_short = 0, m_len_err = 0;
    bit    m_first = 1'b1;
    logic [31:0] m_prev = '0, m_err_cnt = '0;
    bit    hold_pending = 1'b0;
    word_t held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        M_axis_ready = ($urandom_range(99) < rdy_pct);
    end

    always @(negedge Clk) begin
        if (Rst) begin
            hold_pending = 1'b0;
        end else begin
            if (Seq_error)    seen_seq_err++;
            if (Short_packet) seen_short++;
            if (Length_error) seen_len_err++;
            if (hold_pending)
                chk("hold_stable", {M_axis_valid, M_axis_data, M_axis_keep, M_axis_last}, {1'b1, held});
            if (M_axis_valid && M_axis_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else chk("word", {M_axis_data, M_axis_keep, M_axis_last}, exp_q.pop_front());
                got_q.push_back({M_axis_data, M_axis_keep, M_axis_last});
            end
            hold_pending = M_axis_valid && !M_axis_ready;
            held = {M_axis_data, M_axis_keep, M_axis_last};
        end
    end

    // Packet-level expectation: header check, payload chunked into words, length check.
    task automatic model_pkt(input logic [7:0] p[$], input int ulen, input int stop);
        bit    done = (stop == p.size());
        word_t w;
        if (stop < 4) begin
            if (done) m_short++;
        end else begin
            logic [31:0] s = {p[0], p[1], p[2], p[3]};
            if (!m_first && s != m_prev + 32'd1) begin
                m_seq_err++;
                if (m_err_cnt != 32'hFFFF_FFFF) m_err_cnt++;
            end
            m_first = 1'b0;
            m_prev  = s;
            for (int i = 4; i < stop; i += B) begin
                w = '0;
                for (int k = 0; k < B && i + k < stop; k++) begin
                    w.d[k*8 +: 8] = p[i+k];
                    w.k[k] = 1'b1;
                end
                w.l = done && (i + B >= stop);
                exp_q.push_back(w);
            end
        end
        if (done && stop != ulen) m_len_err++;
    endtask

    task automatic send(input logic [7:0] p[$], input int ulen, input int stop, input int gap);
        for (int i = 0; i < stop; i++) begin
            int budget = 0;
            bit ok = 1'b0;
            while ($urandom_range(99) < gap) begin
                Udp_valid = 1'b0;
                @(posedge Clk); #1;
            end
            Udp_valid  = 1'b1;
            Udp_data   = p[i];
            Udp_last   = (i == p.size() - 1);
            Udp_length = (i == 0) ? LW'(ulen) : LW'($urandom);
            do begin
                @(negedge Clk);
                ok = Udp_ready;
                @(posedge Clk); #1;
                budget++;
            end while (!ok && budget < 2000);
            if (!ok) begin
                chk("udp_ready_timeout", 0, 1);
                break;
            end
        end
        Udp_valid = 1'b0;
        Udp_last  = 1'b0;
    endtask

    task automatic pkt(input logic [31:0] seq, input logic [7:0] d[$], input int ulen);
        logic [7:0] p[$];
        p = {seq[31:24], seq[23:16], seq[15:8], seq[7:0]};
        foreach (d[i]) p.push_back(d[i]);
        model_pkt(p, ulen, p.size());
        send(p, ulen, p.size(), 0);
    endtask

    task automatic drain();
        int budget = 0;
        while ((exp_q.size() != 0 || M_axis_valid) && budget < 5000) begin
            @(posedge Clk); #1;
            budget++;
        end
        if (budget >= 5000) chk("drain_timeout", 0, 1);
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Udp_valid = 1'b0;
        Udp_last  = 1'b0;
        Rst       = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst       = 1'b0;
        m_first   = 1'b1;
        m_prev    = '0;
        m_err_cnt = '0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_seq_err"}, seen_seq_err, m_seq_err);
        chk({tag, "_short"}, seen_short, m_short);
        chk({tag, "_len_err"}, seen_len_err, m_len_err);
        chk({tag, "_seq_num"}, Seq_num, m_prev);
        chk({tag, "_err_cnt"}, Seq_error_count, m_err_cnt);
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] p[$];
        logic [31:0] seq;
        int nd, ulen, stop;
        Rst = 1'b1; Udp_valid = 1'b0; Udp_last = 1'b0; Udp_data = '0; Udp_length = '0;
        M_axis_ready = 1'b1;
        do_reset();

        @(negedge Clk);
        chk("rst_ready", Udp_ready, 1);
        chk("rst_valid", M_axis_valid, 0);
        chk("rst_data", M_axis_data, 0);
        chk("rst_keep", M_axis_keep, 0);
        chk("rst_last", M_axis_last, 0);
        chk("rst_seq_num", Seq_num, 0);
        chk("rst_err_cnt", Seq_error_count, 0);
        chk("rst_pulses", {Seq_error, Short_packet, Length_error}, 0);
        @(posedge Clk); #1;

        got_q.delete();
        d = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        pkt(32'd5, d, 12);
        drain();
        chk("t1_nwords", got_q.size(), 2);
        chk("t1_w0", got_q[0], {32'h14131211, 4'hF, 1'b0});
        chk("t1_w1", got_q[1], {32'h18171615, 4'hF, 1'b1});
        chk("t1_seq_num", Seq_num, 5);
        chk("t1_no_pulses", seen_seq_err + seen_short + seen_len_err, 0);

        got_q.delete();
        d = {8'hAA, 8'hBB, 8'hCC};
        pkt(32'd6, d, 7);
        drain();
        chk("t2_nwords", got_q.size(), 1);
        chk("t2_w0", got_q[0], {32'h00CCBBAA, 4'h7, 1'b1});

        got_q.delete();
        d = {8'h00, 8'h00, 8'h00};
        p = d;
        model_pkt(p, 3, 3);
        send(p, 3, 3, 0);
        d = {8'h21, 8'h22};
        pkt(32'd7, d, 6);
        drain();
        chk("t3_short", seen_short, 1);
        chk("t3_no_seq_err", seen_seq_err, 0);
        chk("t3_nwords", got_q.size(), 1);
        chk("t3_seq_num", Seq_num, 7);

        got_q.delete();
        d = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        pkt(32'd8, d, 10);
        drain();
        chk("t4_len_err", seen_len_err, 1);
        chk("t4_nwords", got_q.size(), 2);
        chk("t4_w0", got_q[0], {32'h34333231, 4'hF, 1'b0});
        chk("t4_w1", got_q[1], {32'h00000035, 4'h1, 1'b1});
        check_status("t4");

        do_reset();
        got_q.delete();
        d.delete();
        pkt(32'd5, d, 4);
        pkt(32'd6, d, 4);
        pkt(32'd9, d, 4);
        pkt(32'd10, d, 4);
        drain();
        chk("t5_seq_err", seen_seq_err, 1);
        chk("t5_err_cnt", Seq_error_count, 1);
        chk("t5_seq_num", Seq_num, 10);
        chk("t5_no_words", got_q.size(), 0);
        check_status("t5");

        rdy_pct = 80;
        seq = $urandom;
        for (int pk = 0; pk < 100; pk++) begin
            nd = (pk == 50) ? $urandom_range(2 * B, 300) : $urandom_range(1, 300);
            seq = ($urandom_range(9) == 0 || pk == 51) ? $urandom : seq + 32'd1;
            p = {seq[31:24], seq[23:16], seq[15:8], seq[7:0]};
            for (int i = 0; i < nd; i++) p.push_back(8'($urandom));
            ulen = p.size();
            if ($urandom_range(9) == 0) ulen = ulen + ($urandom_range(1) ? 1 : -1);
            stop = (pk == 50) ? 4 + B : p.size();
            model_pkt(p, ulen, stop);
            send(p, ulen, stop, 10);
            if (pk == 50) begin
                drain();
                do_reset();
            end
        end
        drain();
        check_status("rand");
        chk("rand_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/udp_to_axi.md
# udp_to_axi

Receive-side counterpart of the AXI-to-UDP transmit path. Accepts a UDP payload byte stream whose first four bytes are a big-endian 32-bit sequence number, strips and checks that header, and packs the remaining bytes little-endian into AXI-Stream words. Sits between the Ethernet/UDP receive parser and user logic, and reports sequence gaps, short packets and length mismatches as status pulses and counters.

## Interface
- AXI_DATA_WIDTH, 32: output word width; a multiple of 8 and at least 8; BYTES = AXI_DATA_WIDTH/8.
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Udp_length  in  eth_udp_length_width  payload length in bytes, including the 4-byte header; sampled on the first accepted byte of a packet.
- Udp_data  in  8  payload byte.
- Udp_valid  in  1  byte valid.
- Udp_last  in  1  final byte of packet; qualified by Udp_valid.
- Udp_ready  out  1  byte accepted when Udp_valid && Udp_ready.
- M_axis_valid  out  1  output word valid.
- M_axis_data  out  AXI_DATA_WIDTH  byte k at bits [8k+7:8k]; unused bytes are zero.
- M_axis_keep  out  BYTES  byte-valid mask; all ones except possibly on the last word.
- M_axis_last  out  1  final word of packet.
- M_axis_ready  in  1  downstream accept.
- Seq_num  out  32  sequence number of the most recent complete header.
- Seq_error  out  1  one-cycle pulse on a sequence gap.
- Short_packet  out  1  one-cycle pulse when a packet ends within the header.
- Length_error  out  1  one-cycle pulse when the byte count at Udp_last differs from the sampled Udp_length.
- Seq_error_count  out  32  saturating count of Seq_error pulses.

## Operation
- States: S_HEADER (hdr_idx 0..3) and S_DATA.
- S_HEADER: each accepted byte shifts into the sequence register, MSB first.
  - On the 4th byte, run the sequence check. If not Udp_last, go to S_DATA; if Udp_last, it is a header-only packet: no AXI output, stay in S_HEADER.
  - Udp_last on byte 1..3: pulse Short_packet, discard the partial header, leave the sequence state unchanged, return to hdr_idx 0.
- Sequence check: the first complete header after reset is accepted as-is. After that, the received number must equal expected = previous + 1 (mod 2^32); otherwise pulse Seq_error and increment Seq_error_count (saturating at 0xFFFFFFFF). Either way, Seq_num takes the received value and the expected value resyncs to received + 1.
- S_DATA: accepted bytes fill a pack register at byte index byte_idx (0..BYTES-1).
  - The word is complete when byte_idx = BYTES-1 or on Udp_last. It then moves to the output register with keep = lower (byte_idx+1) bits set, and last = Udp_last.
  - On Udp_last, return to S_HEADER.
- Length check: a byte counter (eth_udp_length_width bits, saturating) counts every accepted byte of the packet, header included. At Udp_last, if count ≠ sampled Udp_length, pulse Length_error. Data is still forwarded unchanged.
- Status pulses fire in the cycle after the byte that triggers them.

## Timing
- Udp_ready = !M_axis_valid || M_axis_ready (combinational). Header bytes use the same rule.
- Latency: M_axis_valid rises on the cycle after the byte that completes a word is accepted. With no backpressure, sustained throughput is 1 byte/cycle.
- Once asserted, M_axis_valid/data/keep/last hold stable until M_axis_ready.
- If the output register is accepted in the same cycle a new word completes, the new word loads with no bubble.
- Reset values: Udp_ready 1 (M_axis_valid 0), M_axis_valid 0, M_axis_data 0, M_axis_keep 0, M_axis_last 0, Seq_num 0, Seq_error 0, Short_packet 0, Length_error 0, Seq_error_count 0. State S_HEADER, hdr_idx 0, first-header flag set.
- Reset mid-packet discards any partial word and header. The next accepted byte is treated as header byte 0.

## Test plan
- Header 00 00 00 05, then bytes 11..18 (Udp_length 12), AXI_DATA_WIDTH 32, M_axis_ready held 1 -> words 0x14131211 and 0x18171615 with keep 0xF, last on the second word. Seq_num = 5, no error pulses.
- Payload 0xAA 0xBB 0xCC after a header (length 7) -> one word 0x00CCBBAA, keep 0x7, last 1.
- Sequence numbers 5, 6, 9, 10 -> exactly one Seq_error (on 9), Seq_error_count = 1, final Seq_num = 10.
- 3-byte packet, then a valid packet with seq 7 -> Short_packet pulse and no AXI output for the first. Second packet gives no Seq_error if the prior seq was 6.
- Udp_length 10 but the packet ends after 9 bytes -> Length_error pulse; all 5 data bytes still output (words 0x.., keep 0xF then 0x1).
- 80% random M_axis_ready over 100 random packets (1-300 data bytes), with Rst asserted mid-packet once -> output matches the packed model byte-for-byte, no data lost or duplicated, and the first packet after reset gives no Seq_error.
